// File: rtl/trig_cmd_sched.sv
// trig_cmd_sched: builds one 32-bit TURF->SURF command word per 8-clock
// command cycle from a trigger FIFO, a round-robin message arbiter and an
// optional PPS flag. Both command fanouts carry the same word.
// Optional feature macro: TRIG_SCHED_PPS_EN (PPS edge detect and flag in [15]).
module trig_cmd_sched #(
  parameter int NREQ            = 3,
  parameter int TRIG_FIFO_DEPTH = 4
) (
  input  logic              sysclk_i,
  input  logic              sysclk_rstn_i,
  input  logic              sysclk_phase_i,
  input  logic              pps_i,
  input  logic [15:0]       trig_tdata,
  input  logic              trig_tvalid,
  output logic              trig_tready,
  input  logic [NREQ-1:0]   msg_valid_i,
  input  logic [8*NREQ-1:0] msg_data_i,
  output logic [NREQ-1:0]   msg_ack_o,
  output logic [31:0]       command67_o,
  output logic [31:0]       command68_o,
  output logic              trig_overlap_o
);

  localparam int AW = $clog2(TRIG_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(TRIG_FIFO_DEPTH);
  localparam logic [AW:0] ONE_CNT  = CW'(1);

  logic        rst_meta;
  logic        rst_n;
  logic        load;
  logic [14:0] fifo_mem [TRIG_FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] fifo_cnt;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;

  logic [1:0]      last_grant;
  logic            grant_any;
  logic [1:0]      grant_idx;
  logic [7:0]      grant_data;
  logic [NREQ-1:0] grant_vec;
  logic            pps_bit;
  logic [31:0]     cmd_word;
  logic            unused_tdata;

  assign load = sysclk_phase_i;

  // Reset asserts immediately, releases two clocks after the external deassert
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  // Trigger FIFO: pointer-difference occupancy, one extra pointer bit for full
  assign fifo_cnt    = wr_ptr - rd_ptr;
  assign fifo_empty  = (fifo_cnt == '0);
  assign fifo_full   = (fifo_cnt == FULL_CNT);
  assign trig_tready = rst_n & ~fifo_full;
  assign push        = trig_tvalid & trig_tready;
  assign pop         = load & ~fifo_empty;

  // FIFO pointers advance on accepted push and on load-edge pop
  always_ff @(posedge sysclk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE_CNT;
      if (pop)  rd_ptr <= rd_ptr + ONE_CNT;
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge sysclk_i) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= trig_tdata[14:0];
  end

  // Round-robin pick: search starts one past the previous winner
  always_comb begin
    int cand;
    cand       = 0;
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_data = '0;
    grant_vec  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      for (int k = 0; k < NREQ; k++) begin
        if (!grant_any && (k == cand) && msg_valid_i[k]) begin
          grant_any    = 1'b1;
          grant_idx    = 2'(k);
          grant_data   = msg_data_i[8*k +: 8];
          grant_vec[k] = 1'b1;
        end
      end
    end
  end

`ifdef TRIG_SCHED_PPS_EN
  logic pps_d;
  logic pps_pend;

  // PPS rising edge arms a pending flag; an edge on the load edge survives it
  always_ff @(posedge sysclk_i or negedge rst_n) begin
    if (!rst_n) begin
      pps_d    <= 1'b0;
      pps_pend <= 1'b0;
    end else begin
      pps_d <= pps_i;
      if (pps_i & ~pps_d) pps_pend <= 1'b1;
      else if (load)      pps_pend <= 1'b0;
    end
  end

  assign pps_bit = pps_pend;
`else
  logic unused_pps;
  assign unused_pps = pps_i;
  assign pps_bit    = 1'b0;
`endif

  assign unused_tdata = trig_tdata[15];

  // Assemble the word from whatever is pending at this clock
  always_comb begin
    cmd_word = '0;
    if (!fifo_empty) begin
      cmd_word[31]    = 1'b1;
      cmd_word[30:16] = fifo_mem[rd_ptr[AW-1:0]];
    end
    cmd_word[15] = pps_bit;
    if (grant_any) begin
      cmd_word[11:10] = grant_idx;
      cmd_word[9]     = 1'b1;
      cmd_word[7:0]   = grant_data;
    end
  end

  // Load edge: both fanout registers capture the word, winner gets its ack
  always_ff @(posedge sysclk_i or negedge rst_n) begin
    if (!rst_n) begin
      command67_o    <= '0;
      command68_o    <= '0;
      msg_ack_o      <= '0;
      last_grant     <= 2'(NREQ - 1);
      trig_overlap_o <= 1'b0;
    end else begin
      msg_ack_o <= '0;
      if (load) begin
        command67_o <= cmd_word;
        command68_o <= cmd_word;
        if (grant_any) begin
          msg_ack_o  <= grant_vec;
          last_grant <= grant_idx;
        end
        if (pop && (fifo_cnt > ONE_CNT)) trig_overlap_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/trig_cmd_sched.md
# trig_cmd_sched

Command-slot scheduler for the TURF→SURF command links. It runs in the sysclk domain and builds one 32-bit command word per 8-clock command cycle. Each word merges three sources: a buffered trigger stream, a round-robin-arbitrated 8-bit message field shared by several requesters, and an optional PPS flag. The word drives both command fanouts (67/68).

## Interface

**Parameters**
- `NREQ`, default 3: number of message requesters (2–4).
- `TRIG_FIFO_DEPTH`, default 4: trigger FIFO depth; power of 2, 2–16.

**Ports**
- `sysclk_i` in 1: system clock; the only clock.
- `sysclk_rstn_i` in 1: asynchronous, active-low reset.
- `sysclk_phase_i` in 1: high for 1 clock in 8; marks the command load edge.
- `pps_i` in 1: sysclk-synchronous PPS, level or pulse.
- `trig_tdata` in 16: [14:0] trigger address; [15] ignored.
- `trig_tvalid` in 1: AXI4S valid.
- `trig_tready` out 1: AXI4S ready.
- `msg_valid_i` in NREQ: per-requester request.
- `msg_data_i` in 8·NREQ: requester k uses bits [8k+7:8k].
- `msg_ack_o` out NREQ: one-clock grant pulse.
- `command67_o` out 32: command word, fanout A.
- `command68_o` out 32: command word, fanout B; identical content in a separate register.
- `trig_overlap_o` out 1: sticky; set when a trigger word is issued while the FIFO still holds ≥1 more entry. Cleared only by reset.

## Operation

**Command word**
- [31] trigger valid.
- [30:16] trigger address.
- [15] PPS.
- [14:12] zero.
- [11:10] message source index.
- [9] message valid.
- [8] zero.
- [7:0] message data.

**Load edge** (edge where `sysclk_phase_i`=1)
- Both command registers load the assembled word and then hold it for 8 clocks.
- Fields with nothing pending are zero. An idle cycle issues 0x00000000.

**Trigger FIFO**
- Push when `trig_tvalid & trig_tready`.
- `trig_tready` = !full, and is forced 0 during reset.
- Pop one entry on each load edge when non-empty. The popped entry fills [31:16] with [31]=1.
- Push and pop on the same edge: occupancy is unchanged. This holds when full: the pop frees a slot, but tready was already 0 that clock, so no push occurs.
- Empty on a load edge: [31:16]=0.

**Message arbiter**
- Round-robin over `msg_valid_i`. The search starts at `last_grant+1` mod NREQ.
- After reset `last_grant`=NREQ-1, so requester 0 has first priority.
- On a load edge with any valid request, the winner k:
  - gets `msg_ack_o[k]`=1 for exactly that clock;
  - has its data latched into [7:0];
  - has its index in [11:10] and [9]=1;
  - becomes `last_grant`.
- Requesters hold valid and data stable until ack. They may drop valid the clock after ack or present new data.
- Only one grant per command cycle.
- Requests asserted or dropped between load edges have no effect.

**PPS**
- Rising-edge detect on `pps_i` through a 1-clock delay register. The edge sets `pps_pend`.
- The next load edge writes [15]=1 and clears `pps_pend`.
- An edge coinciding with a load edge is not lost: `pps_pend` is set and issued at the following load edge.
- Multiple edges before issue collapse into one.

## Timing

- Reset (async assert, sync release internally) clears:
  - all outputs to 0 (both command words, acks, `trig_tready`, `trig_overlap_o`);
  - the FIFO to empty;
  - `pps_pend` and the edge register to 0;
  - `last_grant` to NREQ-1.
- Reset mid-command: outputs go to 0 immediately and queued triggers are discarded. The first load edge after release issues only what arrived after release.
- Trigger latency: a push accepted at edge N into an empty FIFO appears in `command*_o` at the first load edge strictly after N, i.e. 1–8 clocks.
- Ack coincides with the load edge whose word carries that data.
- `command67_o` and `command68_o` are bit-identical on every clock.

## Configuration

- `TRIG_SCHED_PPS_EN` defined: PPS detect and `pps_pend` are implemented; bit [15] behaves as described above.
- Not defined: `pps_i` is unused, no PPS logic is built, and [15] is constant 0.

## Test plan

- **Reset:** assert `sysclk_rstn_i`=0 mid-cycle with 2 triggers queued. All outputs are 0 and `trig_tready`=0. After release, three idle load edges each issue 0x00000000.
- **Single trigger:** push 0x1234 into an empty FIFO 3 clocks before a load edge. Next command word = 0x92340000. `trig_overlap_o` stays 0.
- **Backpressure and overlap:** hold tvalid with 6 addresses (0x0001..0x0006).
  - `trig_tready` drops after 4 accepted.
  - Six successive words carry 0x8001..0x8006 in [31:16], in order, with no loss.
  - `trig_overlap_o`=1.
- **Round-robin:** all 3 requesters valid continuously, data 0xA0/0xB1/0xC2. Successive words are 0x000002A0, 0x000006B1, 0x00000AC2, 0x000002A0. Each ack is 1 clock and aligned to its load edge.
- **PPS (macro defined):** `pps_i` rising on a load edge, with simultaneous trigger 0x0005 and message 0x7F from requester 1.
  - That word = 0x8005067F.
  - Following word = 0x00008000 once the FIFO and requests are exhausted.
  - With the macro undefined, [15] stays 0 throughout.
